// File: rtl/reg_dump_reader_if.sv
// reg_dump_reader_if: register-file extra read port plus dump control and valid/ready word stream
interface reg_dump_reader_if #(parameter int ADDR_W = 5, parameter int DATA_W = 32);
  logic              start;
  logic [ADDR_W-1:0] firstReg;
  logic [ADDR_W-1:0] lastReg;
  logic [ADDR_W-1:0] regAddr;
  logic [DATA_W-1:0] regData;
  logic              outValid;
  logic              outReady;
  logic [ADDR_W-1:0] outIndex;
  logic [DATA_W-1:0] outData;
  logic              busy;
  logic              done;
  modport master (output start, firstReg, lastReg, regData, outReady,
                  input  regAddr, outValid, outIndex, outData, busy, done);
  modport slave  (input  start, firstReg, lastReg, regData, outReady,
                  output regAddr, outValid, outIndex, outData, busy, done);
endinterface

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks a latched register range over the extra read port and streams {index, value} words
module reg_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input logic              clk,
  input logic              reset,
  reg_dump_reader_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] out_index_q, out_index_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              done_q, done_d;
  logic              accept, at_last;
  assign accept  = out_valid_q && bus.outReady;
  assign at_last = idx_q == last_q;
  // Index wraps NUM_REGS-1 -> 0 through natural ADDR_W-bit overflow (NUM_REGS is a power of two)
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        idx_d   = bus.firstReg;
        last_d  = bus.lastReg;
        state_d = READ;
      end
      READ: begin
        out_data_d  = bus.regData;
        out_index_d = idx_q;
        out_valid_d = 1'b1;
        state_d     = WAIT;
      end
      WAIT: if (accept) begin
        out_valid_d = 1'b0;
        done_d      = at_last;
        idx_d       = at_last ? idx_q : idx_q + 1'b1;
        state_d     = at_last ? DONE : READ;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      out_index_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end
  assign bus.regAddr  = state_q == READ ? idx_q : '0;
  assign bus.busy     = state_q == READ || state_q == WAIT;
  assign bus.outValid = out_valid_q;
  assign bus.outIndex = out_index_q;
  assign bus.outData  = out_data_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: randomized dumps checked against a snapshot-of-range reference model
module tb_reg_dump_reader;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] rf [32];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  reg_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) rif ();
  reg_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (.clk(clk), .reset(reset), .bus(rif.slave));
  assign rif.regData = rf[rif.regAddr];
  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle_outputs(input string tag);
    chk({tag, "_valid"}, longint'(rif.outValid), 0);
    chk({tag, "_busy"}, longint'(rif.busy), 0);
    chk({tag, "_done"}, longint'(rif.done), 0);
    chk({tag, "_regaddr"}, longint'(rif.regAddr), 0);
  endtask
  // mode 0: always ready, 1: random ready, 2: 10-cycle stall with write to the word's register, 3: re-pulse start mid-dump
  task automatic run_dump(input int f, input int l, input int mode);
    int n, got, dones, stall, last_acc;
    logic rdy, held;
    logic [4:0] hi;
    logic [31:0] hd;
    int eq_i[$];
    logic [31:0] eq_d[$];
    n = ((l - f + 32) % 32) + 1;
    for (int k = 0; k < n; k++) begin
      eq_i.push_back((f + k) % 32);
      eq_d.push_back(rf[(f + k) % 32]);
    end
    @(negedge clk);
    rif.start = 1'b1;
    rif.firstReg = 5'(f);
    rif.lastReg = 5'(l);
    rif.outReady = 1'b0;
    got = 0; dones = 0; stall = 0; held = 1'b0; last_acc = 0;
    for (int cyc = 1; cyc <= 600 && dones == 0; cyc++) begin
      @(negedge clk);
      rif.start = 1'b0;
      rif.firstReg = 5'($urandom);
      rif.lastReg = 5'($urandom);
      if (mode == 3 && cyc == 4) begin
        rif.start = 1'b1;
        rif.firstReg = 5'd0;
      end
      if (cyc == 1) chk("first_read_busy", longint'(rif.busy), 1);
      if (cyc == 2) chk("first_valid_latency", longint'(rif.outValid), 1);
      if (rif.done) begin
        dones++;
        chk("done_after_last", got, n);
      end else if (rif.outValid) begin
        if (held) begin
          chk("held_index", longint'(rif.outIndex), longint'(hi));
          chk("held_data", longint'(rif.outData), longint'(hd));
        end
        rdy = (mode == 0 || mode == 3) ? 1'b1 : (mode == 2) ? (stall >= 10) : 1'($urandom_range(0, 1));
        if (mode == 2 && stall < 10) begin
          stall++;
          if (stall == 3) rf[rif.outIndex] = 32'h1234;
        end
        rif.outReady = rdy;
        if (rdy) begin
          if (eq_i.size() == 0) chk("extra_word", got + 1, n);
          else begin
            chk("word_index", longint'(rif.outIndex), eq_i.pop_front());
            chk("word_data", longint'(rif.outData), longint'(eq_d.pop_front()));
          end
          got++;
          if (mode == 0 && got > 1) chk("word_spacing", cyc - last_acc, 2);
          last_acc = cyc;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hi = rif.outIndex;
          hd = rif.outData;
        end
      end else begin
        rif.outReady = (mode == 0 || mode == 3);
        if (eq_i.size() > 0) begin
          chk("read_busy", longint'(rif.busy), 1);
          chk("read_regaddr", longint'(rif.regAddr), eq_i[0]);
        end
      end
    end
    chk("done_seen", dones, 1);
    chk("word_count", got, n);
    rif.outReady = 1'b0;
    @(negedge clk);
    idle_outputs("after_done");
  endtask
  initial begin
    reset = 1'b1;
    rif.start = 1'b0;
    rif.firstReg = '0;
    rif.lastReg = '0;
    rif.outReady = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h11111111;
    repeat (3) @(negedge clk);
    idle_outputs("reset");
    chk("reset_index", longint'(rif.outIndex), 0);
    chk("reset_data", longint'(rif.outData), 0);
    reset = 1'b0;
    run_dump(0, 31, 0);
    rf[5] = 32'hDEADBEEF;
    run_dump(5, 5, 0);
    run_dump(30, 1, 0);
    run_dump(7, 7, 2);
    run_dump(10, 20, 3);
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      run_dump(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1);
    end
    @(negedge clk);
    rif.start = 1'b1;
    rif.firstReg = 5'd3;
    rif.lastReg = 5'd9;
    rif.outReady = 1'b0;
    @(negedge clk);
    rif.start = 1'b0;
    for (int c = 0; c < 20 && !rif.outValid; c++) @(negedge clk);
    chk("pre_reset_valid", longint'(rif.outValid), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle_outputs("mid_reset");
    run_dump(12, 14, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
